ifid_queue: RTL and testbench
=============================

// Module: ifid_queue
// PURPOSE
//  Parametrised IF->ID instruction queue; replaces the single-stage IF/ID latch.
//  Buffers DEPTH {npc, instr} pairs so fetch can run ahead while decode stalls.
//  Valid/ready handshake on both sides; flush empties the queue on a branch/jump
//  resolve. Sits between the fetch stage (icache return) and the decode stage.
// PARAMETERS
//  WORD_W  32  width of npc and instr fields (word_t width)
//  DEPTH   4   number of entries; power of 2, >= 2
// PORTS
//  CLK        in   1                 clock, all state updates on rising edge
//  RST        in   1                 synchronous, active-high reset
//  flush      in   1                 discard all entries (branch/jump resolve)
//  enq_valid  in   1                 fetch presents a valid pair
//  enq_npc    in   WORD_W            pc+4 of fetched instruction
//  enq_instr  in   WORD_W            fetched instruction word
//  enq_ready  out  1                 queue accepts pair this cycle
//  deq_valid  out  1                 head entry valid for decode
//  deq_npc    out  WORD_W            head npc
//  deq_instr  out  WORD_W            head instruction
//  deq_ready  in   1                 decode consumes head this cycle
//  count      out  $clog2(DEPTH)+1   entries currently held
// BEHAVIOUR
//  - Storage: DEPTH-entry circular buffer, rd_ptr/wr_ptr of $clog2(DEPTH) bits,
//    wrap modulo DEPTH; occupancy counter 0..DEPTH.
//  - enq fires when enq_valid & enq_ready; deq fires when deq_valid & deq_ready.
//  - enq_ready = (count != DEPTH) & ~flush; purely from state and flush, never
//    from deq_ready (no enqueue into full queue even if head dequeues same cycle).
//  - deq_valid = (count != 0); deq_npc/deq_instr = mem[rd_ptr] (first-word
//    fall-through, no output register). When deq_valid=0, deq_npc/deq_instr = 0.
//  - Latency: pair enqueued in cycle N visible on deq_* in cycle N+1.
//  - Simultaneous enq+deq (0 < count < DEPTH): both fire, count unchanged.
//  - deq_ready with deq_valid=0: no effect. enq_valid with enq_ready=0: dropped,
//    fetch must hold and retry.
//  - flush=1: next cycle rd_ptr=wr_ptr=0, count=0; any enq or deq in the flush
//    cycle is discarded (flush wins). Head still visible during the flush cycle.
//  - RST=1: same as flush, takes priority over all; after reset enq_ready=1,
//    deq_valid=0, deq_npc=0, deq_instr=0, count=0. Reset mid-stream drops all.
//  - Storage array not reset; only pointers/count.
// CONFIGURATION
//  IFID_BYPASS_EN defined: when count==0 and enq_valid & ~flush, deq_valid=1 and
//    deq_npc/deq_instr = enq_npc/enq_instr combinationally; if deq_ready also 1,
//    pair passes through in the same cycle and is NOT written (count stays 0);
//    otherwise it is written as normal. enq_ready unchanged.
//  IFID_BYPASS_EN undefined: no combinational path enq->deq; 1-cycle latency.
// TESTING
//  1 RST 2 cycles -> enq_ready=1, deq_valid=0, count=0, deq_instr=0.
//  2 enq npc=0x4 instr=0x20010001, deq_ready=0 -> next cycle deq_valid=1,
//    deq_instr=0x20010001, count=1; deq_ready=1 one cycle -> count=0.
//  3 deq_ready=0, enq 5 pairs (DEPTH=4) -> enq_ready=0 after 4th, 5th held;
//    drain -> instrs out in order 1..4, then 5th accepted, no loss/duplication.
//  4 count=2, enq+deq same cycle for 10 cycles -> count stays 2, order kept
//    across pointer wrap.
//  5 count=3, flush=1 with enq_valid=1 -> next cycle count=0, deq_valid=0; the
//    flush-cycle enq never appears.
//  6 IFID_BYPASS_EN, empty, enq_valid=1, deq_ready=1, instr=0xAC220004 -> same
//    cycle deq_valid=1, deq_instr=0xAC220004, next cycle count=0; without
//    macro -> deq_valid=0 that cycle, count=1 next.

Source files
------------

// File: rtl/ifid_queue.sv
// ifid_queue: IF->ID instruction queue, DEPTH-entry first-word-fall-through ring.
// Define IFID_BYPASS_EN for a combinational enq->deq pass-through when empty.
module ifid_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [WORD_W-1:0]        enq_npc,
  input  logic [WORD_W-1:0]        enq_instr,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [WORD_W-1:0]        deq_npc,
  output logic [WORD_W-1:0]        deq_instr,
  input  logic                     deq_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [WORD_W-1:0] word_t;

  word_t         mem_npc   [DEPTH];
  word_t         mem_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic empty;
  logic full;
  logic enq_fire;
  logic q_deq;
  logic wr_en;
  logic byp_hit;
  logic byp_pass;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign enq_ready = ~full & ~flush;
  assign enq_fire  = enq_valid & enq_ready;
  assign q_deq     = ~empty & deq_ready;
  assign count     = cnt;

`ifdef IFID_BYPASS_EN
  assign byp_hit = empty & enq_valid & ~flush;
`else
  assign byp_hit = 1'b0;
`endif

  // a bypassed pair consumed this cycle never lands in storage
  assign byp_pass = byp_hit & deq_ready;
  assign wr_en    = enq_fire & ~byp_pass;

  always_comb begin
    deq_valid = 1'b0;
    deq_npc   = '0;
    deq_instr = '0;
    unique case (1'b1)
      !empty: begin
        deq_valid = 1'b1;
        deq_npc   = mem_npc[rd_ptr];
        deq_instr = mem_instr[rd_ptr];
      end
      byp_hit: begin
        deq_valid = 1'b1;
        deq_npc   = enq_npc;
        deq_instr = enq_instr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST | flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (q_deq) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, q_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_npc[wr_ptr]   <= enq_npc;
      mem_instr[wr_ptr] <= enq_instr;
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: vector table, corner sequences and random traffic
// against a queue-based reference model of the IF->ID queue.
module tb_ifid_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          flush;
  logic          enq_valid;
  logic [W-1:0]  enq_npc;
  logic [W-1:0]  enq_instr;
  logic          enq_ready;
  logic          deq_valid;
  logic [W-1:0]  deq_npc;
  logic [W-1:0]  deq_instr;
  logic          deq_ready;
  logic [CW-1:0] count;

  always #5 CLK = ~CLK;

  ifid_queue #(.WORD_W(W), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_npc   (enq_npc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_npc   (deq_npc),
    .deq_instr (deq_instr),
    .deq_ready (deq_ready),
    .count     (count)
  );

  typedef struct {
    logic         r;
    logic         f;
    logic         ev;
    logic [W-1:0] npc;
    logic [W-1:0] ins;
    logic         dr;
    logic         e_er;
    logic         e_dv;
    logic [W-1:0] e_ins;
    int           e_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] mq[$];
  logic [W-1:0]   popped[$];
  logic           acc_enq;
  vec_t           tv[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f,
                              input logic ev, input logic [W-1:0] npc,
                              input logic [W-1:0] ins, input logic dr);
    vec_t v;
    v = '{default: '0};
    v.r = r;
    v.f = f;
    v.ev = ev;
    v.npc = npc;
    v.ins = ins;
    v.dr = dr;
    return v;
  endfunction

  // one clock: drive, check at negedge, advance model at posedge
  task automatic step(input vec_t v, input bit use_tab);
    int             msz;
    logic           m_er;
    logic           m_dv;
    logic           pass;
    logic [2*W-1:0] m_d;
    RST       = v.r;
    flush     = v.f;
    enq_valid = v.ev;
    enq_npc   = v.npc;
    enq_instr = v.ins;
    deq_ready = v.dr;
    msz  = mq.size();
    m_er = (msz != DEPTH) && !v.f;
    m_dv = 1'b0;
    m_d  = '0;
    if (msz != 0) begin
      m_dv = 1'b1;
      m_d  = mq[0];
    end else if (BYP && v.ev && !v.f) begin
      m_dv = 1'b1;
      m_d  = {v.npc, v.ins};
    end
    @(negedge CLK);
    chk("m_enq_ready", 64'(enq_ready), 64'(m_er));
    chk("m_deq_valid", 64'(deq_valid), 64'(m_dv));
    chk("m_deq_data", {deq_npc, deq_instr}, m_d);
    chk("m_count", 64'(count), 64'(msz));
    if (use_tab) begin
      chk("t_enq_ready", 64'(enq_ready), 64'(v.e_er));
      chk("t_deq_valid", 64'(deq_valid), 64'(v.e_dv));
      chk("t_deq_instr", 64'(deq_instr), 64'(v.e_ins));
      chk("t_count", 64'(count), 64'(v.e_cnt));
    end
    acc_enq = enq_valid & enq_ready;
    if (deq_valid && deq_ready) popped.push_back(deq_instr);
    @(posedge CLK);
    if (v.r || v.f) begin
      mq.delete();
    end else begin
      pass = BYP && (msz == 0) && v.ev && v.dr;
      if (msz != 0 && v.dr) mq.delete(0);
      if (v.ev && m_er && !pass) mq.push_back({v.npc, v.ins});
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0, 0, 1, 32'h4,  32'h20010001, 0,
               1, BYP, BYP ? 32'h20010001 : 32'h0, 0};
    tv[1]  = '{0, 0, 0, 32'h0,  32'h0, 1, 1, 1, 32'h20010001, 1};
    tv[2]  = '{0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 32'h0, 0};
    tv[3]  = '{0, 0, 1, 32'h8,  32'h11, 0,
               1, BYP, BYP ? 32'h11 : 32'h0, 0};
    tv[4]  = '{0, 0, 1, 32'hc,  32'h22, 0, 1, 1, 32'h11, 1};
    tv[5]  = '{0, 0, 1, 32'h10, 32'h33, 0, 1, 1, 32'h11, 2};
    tv[6]  = '{0, 1, 1, 32'h14, 32'h44, 0, 0, 1, 32'h11, 3};
    tv[7]  = '{0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 32'h0, 0};
    tv[8]  = '{0, 0, 1, 32'h18, 32'hAC220004, 1,
               1, BYP, BYP ? 32'hAC220004 : 32'h0, 0};
    tv[9]  = '{0, 0, 0, 32'h0,  32'h0, 0,
               1, !BYP, BYP ? 32'h0 : 32'hAC220004, BYP ? 0 : 1};
    tv[10] = '{0, 0, 0, 32'h0,  32'h0, 1,
               1, !BYP, BYP ? 32'h0 : 32'hAC220004, BYP ? 0 : 1};
    tv[11] = '{0, 0, 1, 32'h1c, 32'h55, 0,
               1, BYP, BYP ? 32'h55 : 32'h0, 0};
    tv[12] = '{0, 0, 1, 32'h20, 32'h66, 0, 1, 1, 32'h55, 1};
    tv[13] = '{1, 0, 1, 32'h24, 32'h77, 1, 1, 1, 32'h55, 2};
    tv[14] = '{0, 0, 0, 32'h0,  32'h0, 0, 1, 0, 32'h0, 0};

    RST       = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_npc   = '0;
    enq_instr = '0;
    deq_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    chk("rst_deq_npc", 64'(deq_npc), 64'd0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 15; i++) step(tv[i], 1'b1);

    // fill to full, then drain while the fifth pair retries
    popped.delete();
    for (int k = 0; k < 4; k++)
      step(mk(0, 0, 1, W'(4 * k), W'(k + 1), 0), 1'b0);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    step(mk(0, 0, 1, W'(16), W'(5), 1), 1'b0);
    chk("full_deq_no_enq", 64'(acc_enq), 64'd0);
    begin
      int pending;
      pending = 5;
      for (int c = 0; c < 20 && (mq.size() != 0 || pending <= 5); c++) begin
        step(mk(0, 0, pending <= 5, W'(16), W'(pending), 1), 1'b0);
        if (acc_enq) pending++;
      end
      chk("drain_accepted", 64'(pending), 64'd6);
    end
    chk("drain_total", 64'(popped.size()), 64'd5);
    for (int k = 0; k < popped.size(); k++)
      chk("drain_order", 64'(popped[k]), 64'(k + 1));

    // steady state at count 2 across pointer wrap
    popped.delete();
    step(mk(0, 0, 1, W'(32'h200), W'(32'h100), 0), 1'b0);
    step(mk(0, 0, 1, W'(32'h204), W'(32'h101), 0), 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(mk(0, 0, 1, W'(32'h208 + 4 * k), W'(32'h102 + k), 1), 1'b0);
      chk("steady_count", 64'(count), 64'd2);
    end
    for (int k = 0; k < popped.size(); k++)
      chk("steady_order", 64'(popped[k]), 64'(32'h100 + k));
    step(mk(0, 1, 0, '0, '0, 0), 1'b0);

    for (int n = 0; n < 400; n++) begin
      step(mk($urandom_range(0, 63) == 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) < 7,
              W'($urandom), W'($urandom),
              $urandom_range(0, 9) < 6), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
